ghr_history_manager: RTL and testbench

//  Stateful companion of the branch perceptron predictor. Owns the speculative global

---
 rtl/bp_pkg.sv | 20 ++
 rtl/ghr_history_manager.sv | 118 +++++++++++
 tb/tb_ghr_history_manager.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared types and constants for the branch perceptron predictor and its
// global-history manager.
package bp_pkg;

    localparam int       GHR_ENTRY_W = 33;
    localparam int       GHR_WIN     = 20;
    localparam logic [2:0] PASSB_FLUSH = 3'd7;

    typedef enum logic [1:0] {
        BR_NORMAL = 2'd0,
        BR_B      = 2'd1
    } br_type_e;

    // Packed layout: bit 0 = taken, [32:1] = branch address
    typedef struct packed {
        logic [31:0] addr;
        logic        taken;
    } ghr_entry_t;

endpackage

// File: rtl/ghr_history_manager.sv
// Speculative global history ring with unresolved-branch accounting,
// mispredict squash and one-cycle redirect pulse.
module ghr_history_manager
    import bp_pkg::*;
#(
    parameter int PHYS_DEPTH = 32,
    parameter int WIN_DEPTH  = GHR_WIN,
    parameter int PEND_MAX   = 12
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_fetchValid,
    input  logic [2:0]                         i_passBNum_3,
    input  logic [4*GHR_ENTRY_W-1:0]           i_newGHREntry_132,
    input  logic                               i_resolveValid,
    input  logic                               i_resolveMispredict,
    input  logic [31:0]                        i_resolveCorrectPC_32,
    output logic [WIN_DEPTH*GHR_ENTRY_W-1:0]   o_globalHistoryRegister_660,
    output logic [7:0]                         o_pendingB_8,
    output logic [31:0]                        o_correctPC_32,
    output logic                               o_stall,
    output logic                               o_protocolErr
);

    localparam int PTR_W   = $clog2(PHYS_DEPTH);
    localparam int NEW_MAX = 4;

    ghr_entry_t       buf_q [PHYS_DEPTH];
    ghr_entry_t       buf_d [PHYS_DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [7:0]       pend_q, pend_d;
    logic [31:0]      cpc_q, cpc_d;
    logic             stall_q, stall_d;
    logic             err_q, err_d;

    logic             flush, cnt_ok, app_ok, res_any, mis_ok, res_ok;
    logic [PTR_W-1:0] n_ptr, oldest;

    // A flush cycle is either the redirect pulse cycle or an explicit flush count
    assign flush   = (cpc_q != '0) || (i_passBNum_3 == PASSB_FLUSH);
    assign cnt_ok  = i_passBNum_3 <= 3'(NEW_MAX);
    assign app_ok  = i_fetchValid & ~flush & ~stall_q & cnt_ok;
    assign res_any = i_resolveValid & (pend_q != '0);
    assign mis_ok  = res_any & i_resolveMispredict;
    assign res_ok  = res_any & ~i_resolveMispredict;
    assign n_ptr   = PTR_W'(i_passBNum_3);
    assign oldest  = head_q - PTR_W'(pend_q);

    always_comb begin
        head_d = head_q;
        pend_d = pend_q;
        buf_d  = buf_q;

        // Youngest entry (k=0) lands in the highest slot so window[0] reads it first
        if (app_ok && !mis_ok) begin
            for (int k = 0; k < NEW_MAX; k++) begin
                if (3'(k) < i_passBNum_3)
                    buf_d[head_q + n_ptr - PTR_W'(k + 1)] =
                        i_newGHREntry_132[k*GHR_ENTRY_W +: GHR_ENTRY_W];
            end
        end

        unique casez ({mis_ok, app_ok, res_ok})
            3'b1??: begin
                head_d = oldest + PTR_W'(1);
                pend_d = '0;
                buf_d[oldest].taken = ~buf_q[oldest].taken;
            end
            3'b011: begin
                head_d = head_q + n_ptr;
                pend_d = pend_q + 8'(i_passBNum_3) - 8'd1;
            end
            3'b010: begin
                head_d = head_q + n_ptr;
                pend_d = pend_q + 8'(i_passBNum_3);
            end
            3'b001: pend_d = pend_q - 8'd1;
            default: ;
        endcase
    end

    always_comb begin
        cpc_d   = mis_ok ? i_resolveCorrectPC_32 : '0;
        stall_d = pend_d > 8'(PEND_MAX - NEW_MAX);
        err_d   = err_q
                | (i_fetchValid & ~flush & (stall_q | ~cnt_ok))
                | (i_resolveValid & (pend_q == '0));
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < PHYS_DEPTH; i++) buf_q[i] <= '0;
            head_q  <= '0;
            pend_q  <= '0;
            cpc_q   <= '0;
            stall_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            head_q  <= head_d;
            pend_q  <= pend_d;
            cpc_q   <= cpc_d;
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    for (genvar k = 0; k < WIN_DEPTH; k++) begin : g_win
        assign o_globalHistoryRegister_660[k*GHR_ENTRY_W +: GHR_ENTRY_W] =
            buf_q[head_q - PTR_W'(k + 1)];
    end

    assign o_pendingB_8   = pend_q;
    assign o_correctPC_32 = cpc_q;
    assign o_stall        = stall_q;
    assign o_protocolErr  = err_q;

endmodule

// File: tb/tb_ghr_history_manager.sv
// Self-checking bench for ghr_history_manager: directed table, corner
// sequences and randomized traffic against a ring-of-history reference model.
module tb_ghr_history_manager;
    import bp_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         fv = 1'b0, rv = 1'b0, rm = 1'b0;
    logic [2:0]   passb = '0;
    logic [131:0] ent = '0;
    logic [31:0]  rpc = '0;
    logic [659:0] ghr;
    logic [7:0]   pendb;
    logic [31:0]  cpc;
    logic         stall, perr;

    int vectors = 0;
    int errors  = 0;

    logic [32:0] m_ring [32];
    int          m_head, m_pend;
    logic [31:0] m_pc;
    bit          m_stall, m_err;

    ghr_history_manager dut (
        .i_clk                       (clk),
        .i_rst_n                     (rst_n),
        .i_fetchValid                (fv),
        .i_passBNum_3                (passb),
        .i_newGHREntry_132           (ent),
        .i_resolveValid              (rv),
        .i_resolveMispredict         (rm),
        .i_resolveCorrectPC_32       (rpc),
        .o_globalHistoryRegister_660 (ghr),
        .o_pendingB_8                (pendb),
        .o_correctPC_32              (cpc),
        .o_stall                     (stall),
        .o_protocolErr               (perr)
    );

    always #5 clk = ~clk;

    function automatic int wrap(int x);
        return ((x % 32) + 32) % 32;
    endfunction

    // Entry k has address base+4*(n-1-k), so entry 0 (youngest) is the highest address
    function automatic logic [131:0] mk(logic [31:0] base, int n);
        logic [131:0] v = '0;
        for (int k = 0; k < 4; k++)
            v[k*33 +: 33] = {base + 32'(4 * (n - 1 - k)), (k % 2) == 1};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [659:0] act, input logic [659:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_ring[i] = '0;
        m_head = 0; m_pend = 0; m_pc = '0; m_stall = 0; m_err = 0;
    endtask

    task automatic model_step();
        bit flush = (m_pc != 0) || (passb == 3'd7);
        bit app   = fv && !flush && !m_stall && (passb <= 3'd4);
        bit res   = rv && (m_pend > 0);
        int n     = int'(passb);
        logic [31:0] new_pc = '0;
        if (fv && !flush && (m_stall || passb == 3'd5 || passb == 3'd6)) m_err = 1;
        if (rv && m_pend == 0) m_err = 1;
        if (res && rm) begin
            int old = wrap(m_head - m_pend);
            m_ring[old][0] = ~m_ring[old][0];
            m_head = wrap(old + 1);
            m_pend = 0;
            new_pc = rpc;
        end else begin
            if (app) begin
                for (int k = 0; k < n; k++) m_ring[wrap(m_head + n - 1 - k)] = ent[k*33 +: 33];
                m_head = wrap(m_head + n);
                m_pend += n;
            end
            if (res) m_pend -= 1;
        end
        m_stall = m_pend > 8;
        m_pc = new_pc;
    endtask

    task automatic check_model(input string tag);
        logic [659:0] w = '0;
        for (int k = 0; k < 20; k++) w[k*33 +: 33] = m_ring[wrap(m_head - 1 - k)];
        chk({tag, ".ghr"},     ghr,   w);
        chk({tag, ".pending"}, 660'(pendb), 660'(m_pend));
        chk({tag, ".pc"},      660'(cpc),   660'(m_pc));
        chk({tag, ".stall"},   660'(stall), 660'(m_stall));
        chk({tag, ".err"},     660'(perr),  660'(m_err));
    endtask

    task automatic drive(bit f, int n, logic [31:0] base, bit r, bit m, logic [31:0] pc);
        fv = f; passb = 3'(n); ent = mk(base, n); rv = r; rm = m; rpc = pc;
        model_step();
        @(posedge clk); #1;
    endtask

    task automatic cycle(input string tag, bit f, int n, logic [31:0] base, bit r, bit m,
                         logic [31:0] pc);
        drive(f, n, base, r, m, pc);
        check_model(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; fv = 0; rv = 0; rm = 0; passb = '0; ent = '0; rpc = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit          f;
        int          n;
        logic [31:0] base;
        bit          r;
        bit          m;
        logic [31:0] pc;
        int          e_pend;
        logic [31:0] e_pc;
        bit          e_stall;
        bit          e_err;
        logic [32:0] e_w0;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int rn;
        tbl[0]  = '{1, 4, 32'h40,  0, 0, 32'h0,    4, 32'h0,    0, 0, {32'h4C,  1'b0}};
        tbl[1]  = '{1, 2, 32'h50,  0, 0, 32'h0,    6, 32'h0,    0, 0, {32'h54,  1'b0}};
        tbl[2]  = '{1, 0, 32'h0,   0, 0, 32'h0,    6, 32'h0,    0, 0, {32'h54,  1'b0}};
        tbl[3]  = '{0, 0, 32'h0,   1, 0, 32'h0,    5, 32'h0,    0, 0, {32'h54,  1'b0}};
        tbl[4]  = '{0, 0, 32'h0,   1, 1, 32'h2000, 0, 32'h2000, 0, 0, {32'h44,  1'b1}};
        tbl[5]  = '{0, 0, 32'h0,   0, 0, 32'h0,    0, 32'h0,    0, 0, {32'h44,  1'b1}};
        tbl[6]  = '{1, 1, 32'h80,  0, 0, 32'h0,    1, 32'h0,    0, 0, {32'h80,  1'b0}};
        tbl[7]  = '{1, 4, 32'h100, 1, 0, 32'h0,    4, 32'h0,    0, 0, {32'h10C, 1'b0}};
        tbl[8]  = '{1, 4, 32'h200, 0, 0, 32'h0,    8, 32'h0,    0, 0, {32'h20C, 1'b0}};
        tbl[9]  = '{1, 1, 32'h300, 0, 0, 32'h0,    9, 32'h0,    1, 0, {32'h300, 1'b0}};
        tbl[10] = '{1, 4, 32'h400, 0, 0, 32'h0,    9, 32'h0,    1, 1, {32'h300, 1'b0}};

        @(posedge clk); #1;
        do_reset();
        check_model("reset");
        chk("reset.zero", {ghr, pendb, cpc, stall, perr}, '0);

        // Directed table: appends, resolve, mispredict squash, stall and overflow drop
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].f, tbl[i].n, tbl[i].base, tbl[i].r, tbl[i].m, tbl[i].pc);
            chk($sformatf("tbl%0d.pending", i), 660'(pendb), 660'(tbl[i].e_pend));
            chk($sformatf("tbl%0d.pc", i),      660'(cpc),   660'(tbl[i].e_pc));
            chk($sformatf("tbl%0d.stall", i),   660'(stall), 660'(tbl[i].e_stall));
            chk($sformatf("tbl%0d.err", i),     660'(perr),  660'(tbl[i].e_err));
            chk($sformatf("tbl%0d.w0", i),      660'(ghr[32:0]), 660'(tbl[i].e_w0));
            check_model($sformatf("tbl%0d", i));
        end

        // Reset asserted during the redirect cycle wins over the pending pulse
        cycle("mis2", 0, 0, 0, 1, 1, 32'h3000);
        rst_n = 1'b0; fv = 1; passb = 3'd4; ent = mk(32'h500, 4); rv = 0;
        @(posedge clk); #1;
        model_reset();
        chk("rst_flush.zero", {ghr, pendb, cpc, stall, perr}, '0);
        rst_n = 1'b1;

        // Resolve with nothing pending: error, state untouched
        cycle("res_empty", 0, 0, 0, 1, 0, 0);
        chk("res_empty.err", 660'(perr), 660'(1));
        chk("res_empty.pending", 660'(pendb), 660'(0));

        // Bad count and flush-count cycles
        do_reset();
        cycle("cnt5", 1, 5, 32'h600, 0, 0, 0);
        chk("cnt5.err", 660'(perr), 660'(1));
        do_reset();
        cycle("cnt7", 1, 7, 32'h700, 0, 0, 0);
        chk("cnt7.err", 660'(perr), 660'(0));
        chk("cnt7.pending", 660'(pendb), 660'(0));

        // 40 single appends with trailing resolves: head wraps past the ring end
        do_reset();
        cycle("wrap0", 1, 1, 32'h1000, 0, 0, 0);
        for (int i = 1; i < 40; i++)
            cycle($sformatf("wrap%0d", i), 1, 1, 32'h1000 + 32'(16 * i), 1, 0, 0);
        chk("wrap.pending", 660'(pendb), 660'(1));

        // Randomized traffic, including bad counts, mispredicts and a mid-run reset
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            rn = ($urandom_range(0, 15) == 0) ? int'($urandom_range(5, 7))
                                              : int'($urandom_range(0, 4));
            cycle("rand", $urandom_range(0, 3) != 0, rn, $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
